matrix_mult_engine: RTL and testbench

MATRIX_MULT_ENGINE -- requirements
Module: matrix_mult_engine

---
 rtl/mm_pkg.sv | 10 +
 rtl/matrix_mult_engine_if.sv | 33 +++
 rtl/mm_pe.sv | 43 ++++
 rtl/matrix_mult_engine.sv | 107 ++++++++++
 tb/tb_matrix_mult_engine.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
// mm_pkg: shared state encoding, operand-select codes and default sizing for matrix_mult_engine.
package mm_pkg;
    localparam int MM_DATA_W  = 16;
    localparam int MM_ACC_W   = 40;
    localparam int MM_DIM_MAX = 8;
    localparam int MM_NUM_PE  = 4;
    localparam logic MM_SEL_A = 1'b0;
    localparam logic MM_SEL_B = 1'b1;
    typedef enum logic [1:0] {IDLE, MAC, DRAIN, ERROR} mm_state_t;
endpackage

// File: rtl/matrix_mult_engine_if.sv
// matrix_mult_engine_if: operand load port, launch/status and result stream of matrix_mult_engine.
interface matrix_mult_engine_if #(
    parameter int DATA_W  = mm_pkg::MM_DATA_W,
    parameter int ACC_W   = mm_pkg::MM_ACC_W,
    parameter int DIM_MAX = mm_pkg::MM_DIM_MAX
);
    localparam int AW = $clog2(DIM_MAX * DIM_MAX);
    localparam int DW = $clog2(DIM_MAX + 1);
    localparam int IW = $clog2(DIM_MAX);
    logic              ld_valid;
    logic              ld_ready;
    logic              ld_sel;
    logic [AW-1:0]     ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              start;
    logic [DW-1:0]     dim;
    logic              busy;
    logic              done;
    logic              err;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [IW-1:0]     res_row;
    logic [IW-1:0]     res_col;
    modport master (
        output ld_valid, ld_sel, ld_addr, ld_data, start, dim, res_ready,
        input  ld_ready, busy, done, err, res_valid, res_data, res_row, res_col
    );
    modport slave (
        input  ld_valid, ld_sel, ld_addr, ld_data, start, dim, res_ready,
        output ld_ready, busy, done, err, res_valid, res_data, res_row, res_col
    );
endinterface

// File: rtl/mm_pe.sv
// mm_pe: one signed multiply-accumulate lane.
// MM_SATURATE_EN: clamp at the signed ACC_W limits and hold there for the rest of the pass; otherwise wrap.
module mm_pe #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);
    // Wide enough that the product and the running sum never lose bits before clamping.
    localparam int W = (ACC_W > 2 * DATA_W ? ACC_W : 2 * DATA_W) + 1;
    logic signed [W-1:0] ae, be, prod, sum;
    assign ae   = $signed({{(W - DATA_W){a[DATA_W-1]}}, a});
    assign be   = $signed({{(W - DATA_W){b[DATA_W-1]}}, b});
    assign prod = ae * be;
    assign sum  = (clear ? '0 : $signed({{(W - ACC_W){acc[ACC_W-1]}}, acc})) + prod;
`ifdef MM_SATURATE_EN
    localparam logic signed [W-1:0] MAXV = $signed({{(W - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}});
    localparam logic signed [W-1:0] MINV = ~MAXV;
    logic sat;
    logic signed [W-1:0] clamped;
    assign clamped = sum > MAXV ? MAXV : sum < MINV ? MINV : sum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (en && (clear || !sat)) begin
            acc <= clamped[ACC_W-1:0];
            sat <= sum > MAXV || sum < MINV;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else if (en) acc <= sum[ACC_W-1:0];
    end
`endif
endmodule

// File: rtl/matrix_mult_engine.sv
// matrix_mult_engine: square signed matrix multiply C=A*B, NUM_PE column lanes per pass, results streamed row-major.
// Define MM_SATURATE_EN for saturating accumulators (default: two's-complement wrap).
module matrix_mult_engine
    import mm_pkg::*;
#(
    parameter int DATA_W  = MM_DATA_W,
    parameter int ACC_W   = MM_ACC_W,
    parameter int DIM_MAX = MM_DIM_MAX,
    parameter int NUM_PE  = MM_NUM_PE
) (
    input logic                 clk,
    input logic                 rst_n,
    matrix_mult_engine_if.slave bus
);
    localparam int AW = $clog2(DIM_MAX * DIM_MAX);
    localparam int DW = $clog2(DIM_MAX + 1);
    localparam int IW = $clog2(DIM_MAX);
    localparam int PW = NUM_PE > 1 ? $clog2(NUM_PE) : 1;

    mm_state_t state, nstate;
    logic [IW-1:0] i, k, cb, col;
    logic [PW-1:0] lane;
    logic [DW-1:0] dim_q;
    logic err_q, done_q, in_mac, in_drain, hs, bad, last_k, last_lane, last_grp, last_row;
    logic signed [DATA_W-1:0] mem_a [DIM_MAX*DIM_MAX];
    logic signed [DATA_W-1:0] mem_b [DIM_MAX*DIM_MAX];
    logic signed [DATA_W-1:0] a_op;
    logic signed [ACC_W-1:0]  acc [NUM_PE];

    assign in_mac    = state == MAC;
    assign in_drain  = state == DRAIN;
    assign hs        = in_drain && bus.res_ready;
    assign col       = cb + IW'(lane);
    assign bad       = bus.dim == '0 || bus.dim > DW'(DIM_MAX);
    assign last_k    = DW'(k) == dim_q - DW'(1);
    // Lanes past the active dimension only ever sit at the tail of a group, so the pass just ends early.
    assign last_lane = lane == PW'(NUM_PE - 1) || DW'(col) + DW'(1) >= dim_q;
    assign last_grp  = DW'(cb) + DW'(NUM_PE) >= dim_q;
    assign last_row  = DW'(i) == dim_q - DW'(1);

    assign bus.ld_ready  = state == IDLE;
    assign bus.busy      = state != IDLE;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.res_valid = in_drain;
    assign bus.res_data  = in_drain ? acc[lane] : '0;
    assign bus.res_row   = in_drain ? i : '0;
    assign bus.res_col   = in_drain ? col : '0;

    // Operand storage deliberately survives reset.
    always_ff @(posedge clk) begin
        if (bus.ld_valid && bus.ld_ready && bus.ld_sel == MM_SEL_B) mem_b[bus.ld_addr] <= bus.ld_data;
        if (bus.ld_valid && bus.ld_ready && bus.ld_sel == MM_SEL_A) mem_a[bus.ld_addr] <= bus.ld_data;
    end

    assign a_op = mem_a[AW'(int'(i) * DIM_MAX + int'(k))];

    for (genvar j = 0; j < NUM_PE; j++) begin : g_pe
        mm_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (in_mac && k == '0),
            .en    (in_mac),
            .a     (a_op),
            .b     (mem_b[AW'(int'(k) * DIM_MAX + int'(cb) + j)]),
            .acc   (acc[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            i      <= '0;
            k      <= '0;
            cb     <= '0;
            lane   <= '0;
            dim_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= nstate;
            done_q <= state == ERROR || (hs && last_lane && last_grp && last_row);
            if (state == IDLE && bus.start) begin
                dim_q <= bus.dim;
                err_q <= bad;
                i     <= '0;
                k     <= '0;
                cb    <= '0;
                lane  <= '0;
            end
            if (in_mac) k <= last_k ? '0 : k + IW'(1);
            if (hs) lane <= last_lane ? '0 : lane + PW'(1);
            if (hs && last_lane) cb <= last_grp ? '0 : cb + IW'(NUM_PE);
            if (hs && last_lane && last_grp) i <= i + IW'(1);
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = bus.start ? (bad ? ERROR : MAC) : IDLE;
            MAC:     nstate = last_k ? DRAIN : MAC;
            DRAIN:   nstate = !(hs && last_lane) ? DRAIN : (last_grp && last_row) ? IDLE : MAC;
            default: nstate = IDLE;
        endcase
    end
endmodule

// File: tb/tb_matrix_mult_engine.sv
// tb_matrix_mult_engine: random and directed matrix products checked against a row-major reference product.
module tb_matrix_mult_engine;
    localparam int DATA_W = 16, ACC_W = 40, DIM_MAX = 8, NUM_PE = 4, N = DIM_MAX * DIM_MAX;

    typedef struct {
        int row;
        int col;
        logic [ACC_W-1:0] val;
    } res_t;

    logic clk = 1'b0, rst_n = 1'b0;
    int errors = 0, checks = 0, ready_mode = 0, cyc = 0;
    int ma [N], mb [N];
    res_t exp_q [$];

    always #5 clk = ~clk;

    matrix_mult_engine_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DIM_MAX(DIM_MAX)) bus ();
    matrix_mult_engine_if #(.DATA_W(DATA_W), .ACC_W(16), .DIM_MAX(DIM_MAX)) sbus ();

    matrix_mult_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DIM_MAX(DIM_MAX), .NUM_PE(NUM_PE)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    matrix_mult_engine #(.DATA_W(DATA_W), .ACC_W(16), .DIM_MAX(DIM_MAX), .NUM_PE(NUM_PE)) sdut (
        .clk(clk), .rst_n(rst_n), .bus(sbus));

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, need %0d", name, act, req);
        end
    endtask

    // Reference: C = A*B in plain integer arithmetic, truncated to ACC_W, row-major order.
    task automatic model(input int d);
        for (int r = 0; r < d; r++)
            for (int c = 0; c < d; c++) begin
                longint s = 0;
                for (int x = 0; x < d; x++) s += longint'(ma[r*DIM_MAX+x]) * longint'(mb[x*DIM_MAX+c]);
                exp_q.push_back('{r, c, ACC_W'(s)});
            end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.res_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result: unexpected (%0d,%0d)=%0d, none required", bus.res_row, bus.res_col,
                         $signed(bus.res_data));
            end else begin
                if (int'(bus.res_row) != exp_q[0].row || int'(bus.res_col) != exp_q[0].col ||
                    bus.res_data != exp_q[0].val) begin
                    errors++;
                    $display("FAIL result: got (%0d,%0d)=%0d, need (%0d,%0d)=%0d", bus.res_row, bus.res_col,
                             $signed(bus.res_data), exp_q[0].row, exp_q[0].col, $signed(exp_q[0].val));
                end
                if (bus.res_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        bus.res_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
    end

    task automatic load_mats();
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < N; x++) begin
                bus.ld_valid = 1'b1;
                bus.ld_sel   = s[0];
                bus.ld_addr  = x[5:0];
                bus.ld_data  = s == 1 ? 16'(mb[x]) : 16'(ma[x]);
                @(posedge clk);
                #1;
            end
        bus.ld_valid = 1'b0;
    endtask

    task automatic rand_mats();
        logic signed [15:0] t;
        for (int x = 0; x < N; x++) begin
            t = 16'($urandom);
            ma[x] = t;
            t = 16'($urandom);
            mb[x] = t;
        end
        load_mats();
    endtask

    task automatic run(input int d, input int mode, input bit poke);
        int n, first, tot;
        ready_mode = mode;
        model(d);
        bus.start = 1'b1;
        bus.dim   = d[3:0];
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk(bus.busy && !bus.err, "start busy/err", {bus.busy, bus.err}, 2);
        n = 1;
        first = 0;
        while (!bus.done && n < 5000) begin
            if (bus.res_valid && first == 0) first = n;
            if (poke && n == 2) begin
                bus.ld_valid = 1'b1;
                bus.ld_sel   = 1'b0;
                bus.ld_addr  = '0;
                bus.ld_data  = 16'h1234;
            end
            if (n == 3) bus.ld_valid = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        bus.ld_valid = 1'b0;
        chk(bus.done, "done seen", n, 5000);
        if (mode == 0) begin
            tot = 0;
            for (int c = 0; c < d; c += NUM_PE) tot += d + (d - c < NUM_PE ? d - c : NUM_PE);
            tot = d * tot + 1;
            chk(first == d + 1, "first res_valid latency", first, d + 1);
            chk(n == tot, "cycles to done", n, tot);
        end
        chk(exp_q.size() == 0, "results outstanding", exp_q.size(), 0);
        @(posedge clk);
        #1;
        chk(!bus.done && !bus.busy && bus.ld_ready, "idle after done", {bus.done, bus.busy, bus.ld_ready}, 1);
        exp_q.delete();
    endtask

    task automatic err_run(input int d);
        bus.start = 1'b1;
        bus.dim   = d[3:0];
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk({bus.err, bus.busy, bus.done, bus.res_valid} == 4'b1100, "error entry", {bus.err, bus.busy, bus.done, bus.res_valid}, 12);
        @(posedge clk);
        #1;
        chk({bus.err, bus.busy, bus.done, bus.res_valid} == 4'b1010, "error done", {bus.err, bus.busy, bus.done, bus.res_valid}, 10);
        @(posedge clk);
        #1;
        chk({bus.err, bus.done, bus.res_valid} == 3'b100, "error sticky", {bus.err, bus.done, bus.res_valid}, 4);
    endtask

    initial begin
        bit ok;
        int n;
        logic [15:0] sat_exp;
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
        ok = 0; n = 0; sat_exp = '0;
    end

    initial begin
        bit ok;
        int n;
        logic [15:0] sat_exp;
        bus.ld_valid = 0; bus.ld_sel = 0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.start = 0; bus.dim = '0; bus.res_ready = 1;
        sbus.ld_valid = 0; sbus.ld_sel = 0; sbus.ld_addr = '0; sbus.ld_data = '0;
        sbus.start = 0; sbus.dim = '0; sbus.res_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk({bus.busy, bus.done, bus.err, bus.res_valid, bus.ld_ready} == 5'b00001, "reset flags",
            {bus.busy, bus.done, bus.err, bus.res_valid, bus.ld_ready}, 1);
        chk(bus.res_data == 0 && bus.res_row == 0 && bus.res_col == 0, "reset result", bus.res_data, 0);

        for (int x = 0; x < N; x++) begin ma[x] = 0; mb[x] = 0; end
        ma[0] = 1; ma[1] = 2; ma[8] = 3; ma[9] = 4;
        mb[0] = 5; mb[1] = 6; mb[8] = 7; mb[9] = 8;
        load_mats();
        model(2);
        chk(exp_q[0].val == 19 && exp_q[1].val == 22 && exp_q[2].val == 43 && exp_q[3].val == 50,
            "model 2x2", exp_q[3].val, 50);
        exp_q.delete();
        run(2, 0, 0);

        for (int x = 0; x < N; x++) begin ma[x] = (x / 8 == x % 8) ? 1 : 0; mb[x] = x; end
        load_mats();
        model(8);
        ok = 1;
        for (int x = 0; x < N; x++)
            if (exp_q[x].val != ACC_W'(x) || exp_q[x].row != x / 8 || exp_q[x].col != x % 8) ok = 0;
        chk(ok, "model identity", ok, 1);
        exp_q.delete();
        run(8, 0, 0);

        err_run(0);
        err_run(9);
        run(2, 0, 0);

        rand_mats();
        run(3, 1, 0);
        run(5, 2, 1);
        run(8, 2, 0);
        run(6, 0, 0);
        run(1, 0, 0);

        bus.start = 1'b1;
        bus.dim   = 4'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk({bus.busy, bus.done, bus.err, bus.res_valid} == 4'b0000 && bus.res_data == 0 &&
            bus.res_row == 0 && bus.res_col == 0, "async reset mid-MAC", {bus.busy, bus.done, bus.err, bus.res_valid}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk(bus.ld_ready, "ld_ready after reset", bus.ld_ready, 1);
        run(4, 0, 0);

        sbus.ld_valid = 1'b1;
        sbus.ld_sel   = 1'b0;
        sbus.ld_data  = 16'h7FFF;
        @(posedge clk);
        #1;
        sbus.ld_sel = 1'b1;
        @(posedge clk);
        #1;
        sbus.ld_valid = 1'b0;
        sbus.start    = 1'b1;
        sbus.dim      = 4'd1;
        @(posedge clk);
        #1;
        sbus.start = 1'b0;
        n = 1;
        while (!sbus.res_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
`ifdef MM_SATURATE_EN
        sat_exp = 16'h7FFF;
`else
        sat_exp = 16'h0001;
`endif
        chk(n == 2, "narrow acc latency", n, 2);
        chk(sbus.res_data == sat_exp, "narrow acc overflow", sbus.res_data, sat_exp);
        @(posedge clk);
        #1;
        chk(sbus.done && !sbus.res_valid, "narrow acc done", {sbus.done, sbus.res_valid}, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
